// File: rtl/digit_counter_display_pkg.sv
// Shared constants for the digit counter: seven-segment glyphs (active-low,
// bit 0 = segment a .. bit 6 = segment g), digit maxima and small helpers.
package digit_counter_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] HEX_MAX = 4'hF;
    localparam logic [3:0] BCD_MAX = 4'h9;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Loaded digits above the digit maximum are stored as the maximum.
    function automatic logic [3:0] clamp_digit(input logic [3:0] digit,
                                               input logic [3:0] max_digit);
        logic [3:0] result;
        if (digit > max_digit) begin
            result = max_digit;
        end else begin
            result = digit;
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_counter_display_cell.sv
// digit_cell: one 4-bit counter digit with synchronous clear/load, ripple
// step in/out, and a hold input used by the saturating build.
module digit_cell
    import digit_counter_display_pkg::*;
#(
    parameter int BCD = 0
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step_in,
    input  logic       up,
    input  logic       hold,
    output logic       step_out,
    output logic [3:0] digit
);

    localparam logic [3:0] DIGIT_MAX = (BCD != 0) ? BCD_MAX : HEX_MAX;

    logic [3:0] r_digit;
    logic [3:0] w_next;
    logic [3:0] w_load;
    logic       w_at_term;

    // Terminal detection, wrap-around next value and clamped load value.
    always_comb begin
        w_load    = clamp_digit(load_digit, DIGIT_MAX);
        w_at_term = 1'b0;
        w_next    = r_digit;
        if (up) begin
            w_at_term = (r_digit == DIGIT_MAX);
            if (r_digit == DIGIT_MAX) begin
                w_next = 4'h0;
            end else begin
                w_next = r_digit + 4'h1;
            end
        end else begin
            w_at_term = (r_digit == 4'h0);
            if (r_digit == 4'h0) begin
                w_next = DIGIT_MAX;
            end else begin
                w_next = r_digit - 4'h1;
            end
        end
    end

    // Digit register: clear, then load, then step, else hold.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_digit <= 4'h0;
        end else if (load) begin
            r_digit <= w_load;
        end else if (step_in && !hold) begin
            r_digit <= w_next;
        end else begin
            r_digit <= r_digit;
        end
    end

    assign step_out = step_in & w_at_term;
    assign digit    = r_digit;

endmodule

// File: rtl/digit_counter_display.sv
// Multi-digit up/down hex or BCD counter with seven-segment outputs.
// Define DIGIT_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module digit_counter_display
    import digit_counter_display_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BCD    = 0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [7*DIGITS-1:0]   hex
);

    // w_carry[k] is high when a step reaches digit k; w_carry[DIGITS] means
    // every digit sits at its terminal value while enabled.
    logic [DIGITS:0] w_carry;
    logic            w_hold;

    assign w_carry[0] = enable;

`ifdef DIGIT_COUNTER_SATURATE_EN
    assign w_hold = w_carry[DIGITS];
`else
    assign w_hold = 1'b0;
`endif

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            digit_cell #(
                .BCD (BCD)
            ) u_cell (
                .clk        (clk),
                .clear      (clear),
                .load       (load),
                .load_digit (load_value[4*k +: 4]),
                .step_in    (w_carry[k]),
                .up         (up),
                .hold       (w_hold),
                .step_out   (w_carry[k+1]),
                .digit      (count[4*k +: 4])
            );

            assign hex[7*k +: 7] = seg_decode(count[4*k +: 4]);
        end
    endgenerate

    assign tc = w_carry[DIGITS] & ~load & ~clear;

endmodule

// File: tb/tb_digit_counter_display.sv
// Randomized self-checking bench: a hex and a BCD instance share stimulus and
// are compared every cycle against integer-arithmetic reference models.
module tb_digit_counter_display;

`ifdef DIGIT_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        clear;
    logic        enable;
    logic        up;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count_h;
    logic [15:0] count_b;
    logic        tc_h;
    logic        tc_b;
    logic [27:0] hex_h;
    logic [27:0] hex_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] hex_m;
    int          bcd_m;
    logic        last_tc_h;
    logic        last_tc_b;
    logic [6:0]  glyph [16];

    digit_counter_display #(.DIGITS(4), .BCD(0)) u_dut_hex (
        .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count_h), .tc(tc_h), .hex(hex_h)
    );

    digit_counter_display #(.DIGITS(4), .BCD(1)) u_dut_bcd (
        .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count_b), .tc(tc_b), .hex(hex_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int bcd_load(input logic [15:0] lv);
        int v;
        int d;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [27:0] glyphs(input logic [15:0] v);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = glyph[v[4*i +: 4]];
        return r;
    endfunction

    task automatic do_cycle(input logic c, input logic ld, input logic en,
                            input logic u, input logic [15:0] lv);
        logic exp_tc_h;
        logic exp_tc_b;
        int   hv;
        clear = c; load = ld; enable = en; up = u; load_value = lv;
        #1;
        exp_tc_h = en & ~ld & ~c & (u ? (hex_m == 16'hFFFF) : (hex_m == 16'h0000));
        exp_tc_b = en & ~ld & ~c & (u ? (bcd_m == 9999) : (bcd_m == 0));
        last_tc_h = tc_h;
        last_tc_b = tc_b;
        check_eq("tc_hex", {31'b0, tc_h}, {31'b0, exp_tc_h});
        check_eq("tc_bcd", {31'b0, tc_b}, {31'b0, exp_tc_b});
        @(posedge clk);
        if (c) begin
            hex_m = 16'h0000;
            bcd_m = 0;
        end else if (ld) begin
            hex_m = lv;
            bcd_m = bcd_load(lv);
        end else if (en) begin
            hv = int'(hex_m);
            if (u) begin
                if (hv == 65535) hv = SAT ? 65535 : 0; else hv = hv + 1;
                if (bcd_m == 9999) bcd_m = SAT ? 9999 : 0; else bcd_m = bcd_m + 1;
            end else begin
                if (hv == 0) hv = SAT ? 0 : 65535; else hv = hv - 1;
                if (bcd_m == 0) bcd_m = SAT ? 0 : 9999; else bcd_m = bcd_m - 1;
            end
            hex_m = 16'(hv);
        end
        #1;
        check_eq("count_hex", {16'b0, count_h}, {16'b0, hex_m});
        check_eq("count_bcd", {16'b0, count_b}, {16'b0, to_bcd(bcd_m)});
        check_eq("seg_hex", {4'b0, hex_h}, {4'b0, glyphs(hex_m)});
        check_eq("seg_bcd", {4'b0, hex_b}, {4'b0, glyphs(to_bcd(bcd_m))});
    endtask

    initial begin
        int sel;
        logic [15:0] lv;
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
        hex_m = 16'h0000; bcd_m = 0;
        clear = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b1; load_value = 16'h0000;
        @(posedge clk);
        #1;

        // Reset state and clear over a loaded value
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        check_eq("reset_tc", {31'b0, last_tc_h}, 32'd0);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
        check_eq("load_1234", {16'b0, count_h}, 32'h1234);
        do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        check_eq("clear_count", {16'b0, count_h}, 32'h0000);
        check_eq("clear_seg", {4'b0, hex_h}, {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});

        // Hex up-wrap from FFFE
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        check_eq("upwrap_ffff", {16'b0, count_h}, 32'hFFFF);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        check_eq("upwrap_tc", {31'b0, last_tc_h}, 32'd1);
        check_eq("upwrap_end", {16'b0, count_h}, SAT ? 32'hFFFF : 32'h0000);

        // BCD down-wrap from 0001
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("dnwrap_0000", {16'b0, count_b}, 32'h0000);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("dnwrap_tc", {31'b0, last_tc_b}, 32'd1);
        check_eq("dnwrap_end", {16'b0, count_b}, SAT ? 32'h0000 : 32'h9999);

        // BCD load clamp and ripple
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0A99);
        check_eq("bcd_clamp", {16'b0, count_b}, 32'h0999);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        check_eq("bcd_ripple", {16'b0, count_b}, 32'h1000);

        // Priority: clear over load/enable, then load over enable
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0042);
        check_eq("prio_clear", {16'b0, count_h}, 32'h0000);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0042);
        check_eq("prio_load", {16'b0, count_h}, 32'h0042);

        if (SAT) begin
            do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
            for (int i = 0; i < 3; i++) begin
                do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
                check_eq("sat_tc", {31'b0, last_tc_h}, 32'd1);
                check_eq("sat_hold", {16'b0, count_h}, 32'hFFFF);
            end
        end

        // Randomized traffic biased toward boundary values
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       lv = 16'hFFFF;
                1:       lv = 16'h0000;
                2:       lv = 16'h9999;
                3:       lv = 16'hFFFE;
                default: lv = 16'($urandom);
            endcase
            do_cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), lv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
